dec_to_bcd_encoder: RTL and testbench
=====================================

// Module: dec_to_bcd_encoder
// PURPOSE
//   10-line to 4-bit BCD encoder: the inverse of the BCD-to-decimal decoder, built for keypad and
//   coin/DIP-switch lines. Inputs are asynchronous active-low lines.
//   Each line is synchronised, priority-encoded (9 highest, as the SN74LS147), debounced,
//   and presented as a registered BCD code with a valid/ack handshake to the CPU-side logic.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable cycles needed to accept a press or a release (>=1)
//   REPEAT_CYCLES    64  auto-repeat period in cycles; used only with DEC_ENC_AUTOREPEAT_EN (>=1)
// PORTS
//   _CLK     in   1   system clock, rising edge
//   _RST     in   1   asynchronous reset, active-high
//   _IN_N    in   10  decimal lines, active-low, asynchronous; bit n = digit n
//   _ACK     in   1   consumer acknowledge; sampled only while _VALID=1
//   _A,_B,_C,_D out 1 each  registered BCD code (_A = LSB), active-high
//   _VALID   out  1   code available; held until acknowledged
//   _MULTI   out  1   more than one line was low when the code qualified
//   _OVR     out  1   new code qualified while the previous one was still unacknowledged
// BEHAVIOUR
//   Reset: async, active-high. Effects are immediate on assertion:
//     - all outputs go to 0 and the FSM goes to IDLE
//     - sync flops go to all-ones (inactive) and counters go to 0
//     - a reset asserted mid-operation discards any pending code
//   Sync: 2-flop synchroniser per line. Encoding uses only the synchronised value.
//   Encode: enc = index of the highest low line; none = no line low. Width of cnt is $clog2(DEBOUNCE_CYCLES+1).
//   FSM:
//     IDLE    - none: stay.
//             - else: cand<=enc, cnt<=1, ->QUAL.
//     QUAL    - enc==cand and cnt==DEBOUNCE_CYCLES-1: latch D..A<=cand and _MULTI, set _VALID.
//               If _VALID was already 1, set _OVR. Then ->HOLD.
//             - enc==cand, not yet counted out: cnt++.
//             - enc!=cand, enc valid: cand<=enc, cnt<=1.
//             - none: ->IDLE.
//     HOLD    - any key still low: stay. Other keys pressed here are ignored; there is no re-encode.
//             - none: cnt<=1, ->RELEASE.
//     RELEASE - none for DEBOUNCE_CYCLES consecutive cycles (cnt==DEBOUNCE_CYCLES-1): ->IDLE.
//             - any key low: ->HOLD. This is bounce, so no new _VALID is raised.
//   Latency: first clock edge sampling a stable low line = edge 1; _VALID is high after edge
//     2+DEBOUNCE_CYCLES (2 sync + debounce). With DEBOUNCE_CYCLES=1, qualification happens on entry.
//   Handshake:
//     - _ACK=1 with _VALID=1 clears _VALID and _OVR at the next edge.
//     - _ACK with _VALID=0 is ignored.
//     - Qualify and ACK in the same cycle: the new code wins, _VALID stays 1 and _OVR is not set.
//   Outputs D..A and _MULTI hold their last value after ACK until the next qualification.
//   Outputs are purely registered; there are no combinational paths from the inputs.
// CONFIGURATION
//   DEC_ENC_AUTOREPEAT_EN defined:
//     - In HOLD with _VALID=0, a repeat counter counts REPEAT_CYCLES cycles, then raises _VALID
//       again with the same code.
//     - The repeat counter is cleared on leaving HOLD and on each re-raise.
//     - A repeat never sets _OVR; it only fires while _VALID=0.
//   DEC_ENC_AUTOREPEAT_EN undefined:
//     - The repeat counter is not instantiated.
//     - Exactly one _VALID per debounced press.
// TESTING   (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
//   1. Hold _IN_N[7]=0 for 12 cycles, _ACK=0 -> _VALID=1 after edge 6, DCBA=0111, _MULTI=0.
//      Then pulse _ACK for 1 cycle -> _VALID=0 next edge.
//   2. Bounce: _IN_N[3] low 2 cycles, high 1, then low steady -> one _VALID only, 6 edges after the
//      final fall, DCBA=0011. A release bounce of 2 cycles -> no second _VALID.
//   3. _IN_N[2] and _IN_N[9] low together -> DCBA=1001, _MULTI=1.
//   4. Key 5 qualifies with no ack; release for 6 cycles; key 1 pressed -> DCBA=0001, _VALID=1, _OVR=1.
//      _ACK then clears both.
//   5. Assert _RST while in HOLD with _VALID=1 -> all outputs 0 before the next edge.
//      After release of reset, a key held throughout qualifies again after 6 edges.
//   6. Key 4 held 40 cycles, ACK each _VALID -> with macro: repeated _VALID, 8 cycles after each ACK.
//      Without macro: a single _VALID.

Source files
------------

// File: rtl/dec_to_bcd_encoder_if.sv
// Bus between the decimal-line encoder and its consumer.
// The master side drives the active-low lines and the acknowledge;
// the slave side (the encoder) returns the registered BCD code and flags.
interface dec_to_bcd_encoder_if;
    logic [9:0] in_n;
    logic       ack;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       valid;
    logic       multi;
    logic       ovr;

    modport master (
        output in_n, ack,
        input  a, b, c, d, valid, multi, ovr
    );

    modport slave (
        input  in_n, ack,
        output a, b, c, d, valid, multi, ovr
    );
endinterface

// File: rtl/dec_to_bcd_encoder.sv
// 10-line to 4-bit BCD priority encoder (digit 9 highest) with per-line
// two-flop synchronisers, press/release debounce and a valid/ack handshake.
// Optional feature: define DEC_ENC_AUTOREPEAT_EN to re-raise the code every
// REPEAT_CYCLES cycles while a key stays held and the previous code was taken.
module dec_to_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    dec_to_bcd_encoder_if.slave   bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit            SINGLE   = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("dec_to_bcd_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, QUAL, HOLD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    sync1_q, sync2_q;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          multi_q, multi_d;
    logic          ovr_q, ovr_d;
    logic [3:0]    enc;
    logic          none;
    logic          many;

`ifdef DEC_ENC_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // Two-flop synchroniser on every line; idle (all ones) out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.in_n;
            sync2_q <= sync1_q;
        end
    end

    // Priority encode the synchronised lines: the highest low line wins.
    always_comb begin
        enc  = 4'd0;
        none = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!sync2_q[i]) begin
                enc  = 4'(i);
                none = 1'b0;
            end
        end
        many = ($countones(~sync2_q) > 1);
    end

    // Debounce FSM, handshake and code latching; a qualify beats a same-cycle ack.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;
        ovr_d   = ovr_q;
`ifdef DEC_ENC_AUTOREPEAT_EN
        rpt_d   = '0;
`endif
        if (valid_q && bus.ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!none) begin
                    if (SINGLE) begin
                        code_d  = enc;
                        multi_d = many;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !bus.ack;
                        state_d = HOLD;
                    end else begin
                        cand_d  = enc;
                        cnt_d   = CNT_ONE;
                        state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (none) begin
                    state_d = IDLE;
                end else if (enc == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        code_d  = cand_q;
                        multi_d = many;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !bus.ack;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cand_d = enc;
                    cnt_d  = CNT_ONE;
                end
            end
            HOLD: begin
                if (none) begin
                    if (SINGLE) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = RELEASE;
                    end
                end
`ifdef DEC_ENC_AUTOREPEAT_EN
                else if (!valid_q) begin
                    if (rpt_q == RPT_LAST) begin
                        valid_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RPT_ONE;
                    end
                end
`endif
            end
            RELEASE: begin
                if (!none) begin
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything and drops any pending code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef DEC_ENC_AUTOREPEAT_EN
    // Auto-repeat counter; only advances in HOLD while no code is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign bus.a     = code_q[0];
    assign bus.b     = code_q[1];
    assign bus.c     = code_q[2];
    assign bus.d     = code_q[3];
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;
    assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_dec_to_bcd_encoder.sv
// Self-checking bench for dec_to_bcd_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// Expected codes are queued when a press is driven and popped when the code appears.
// Honours DEC_ENC_AUTOREPEAT_EN for the held-key repeat scenario.
module tb_dec_to_bcd_encoder;
    localparam int DEB = 4;
    localparam int RPT = 8;

    typedef struct {
        logic [3:0] code;
        logic       multi;
        logic       ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   rises  = 0;
    logic valid_prev = 1'b0;
    exp_t expq[$];

    dec_to_bcd_encoder_if bus_if();

    dec_to_bcd_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Count rising edges of valid, sampled shortly after each active edge.
    always @(posedge clk) begin
        #2;
        if (bus_if.valid && !valid_prev) rises++;
        valid_prev = bus_if.valid;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait n falling edges; inputs are driven and outputs sampled there.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive the lines and optionally queue the code that should come out.
    task automatic applyStimulus(input logic [9:0] lines, input bit push,
                                 input logic [3:0] code, input logic multi, input logic ovr);
        exp_t e;
        bus_if.in_n = lines;
        if (push) begin
            e.code  = code;
            e.multi = multi;
            e.ovr   = ovr;
            expq.push_back(e);
        end
    endtask

    function automatic logic [3:0] dcba();
        return {bus_if.d, bus_if.c, bus_if.b, bus_if.a};
    endfunction

    // Pop the oldest expected code and compare it with what the DUT presents.
    task automatic compareHead(input string tag);
        exp_t e;
        checkOutput({tag, "_sb_nonempty"}, 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput({tag, "_valid"}, 32'(bus_if.valid), 32'd1);
            checkOutput({tag, "_dcba"},  32'(dcba()),       32'(e.code));
            checkOutput({tag, "_multi"}, 32'(bus_if.multi), 32'(e.multi));
            checkOutput({tag, "_ovr"},   32'(bus_if.ovr),   32'(e.ovr));
        end
    endtask

    // Bounded wait for valid; an expired budget is reported as a failure.
    task automatic waitValid(input string tag, input int max_cycles);
        int n = 0;
        while (!bus_if.valid && n < max_cycles) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_valid_wait"}, 32'(bus_if.valid), 32'd1);
    endtask

    // One-cycle acknowledge pulse.
    task automatic pulseAck();
        bus_if.ack = 1'b1;
        tick(1);
        bus_if.ack = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        int r0;
        int seen;
        int first_at;
        int second_at;

        rst         = 1'b1;
        bus_if.in_n = '1;
        bus_if.ack  = 1'b0;
        tick(2);
        checkOutput("rst_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("rst_dcba",  32'(dcba()),       32'd0);
        checkOutput("rst_multi", 32'(bus_if.multi), 32'd0);
        checkOutput("rst_ovr",   32'(bus_if.ovr),   32'd0);
        rst = 1'b0;
        tick(2);

        // Key 7 held; valid appears after edge 6, then ack clears it.
        applyStimulus(~(10'd1 << 7), 1'b1, 4'd7, 1'b0, 1'b0);
        tick(5);
        checkOutput("t1_early", 32'(bus_if.valid), 32'd0);
        tick(1);
        compareHead("t1");
        tick(6);
        checkOutput("t1_held", 32'(bus_if.valid), 32'd1);
        pulseAck();
        checkOutput("t1_ack_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("t1_code_hold", 32'(dcba()),       32'd7);
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(10);

        // Key 3 bounces on press and on release: exactly one qualification.
        r0 = rises;
        applyStimulus(~(10'd1 << 3), 1'b0, 4'd0, 1'b0, 1'b0);
        tick(2);
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(~(10'd1 << 3), 1'b1, 4'd3, 1'b0, 1'b0);
        tick(5);
        checkOutput("t2_early", 32'(bus_if.valid), 32'd0);
        tick(1);
        compareHead("t2");
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(2);
        applyStimulus(~(10'd1 << 3), 1'b0, 4'd0, 1'b0, 1'b0);
        tick(3);
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(10);
        checkOutput("t2_no_requal_ovr", 32'(bus_if.ovr), 32'd0);
        checkOutput("t2_one_rise",      32'(rises - r0), 32'd1);
        pulseAck();
        checkOutput("t2_ack_valid", 32'(bus_if.valid), 32'd0);
        tick(4);

        // Keys 2 and 9 together: 9 wins and multi is flagged.
        applyStimulus(~10'b10_0000_0100, 1'b1, 4'd9, 1'b1, 1'b0);
        waitValid("t3", 20);
        compareHead("t3");
        pulseAck();
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(10);

        // Key 5 left unacknowledged, then key 1 qualifies: overrun.
        applyStimulus(~(10'd1 << 5), 1'b1, 4'd5, 1'b0, 1'b0);
        waitValid("t4a", 20);
        compareHead("t4a");
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(6);
        applyStimulus(~(10'd1 << 1), 1'b1, 4'd1, 1'b0, 1'b1);
        tick(5);
        checkOutput("t4_before_dcba", 32'(dcba()),     32'd5);
        checkOutput("t4_before_ovr",  32'(bus_if.ovr), 32'd0);
        tick(1);
        compareHead("t4b");
        pulseAck();
        checkOutput("t4_ack_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("t4_ack_ovr",   32'(bus_if.ovr),   32'd0);
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(10);

        // Reset while holding a pending code; the held key qualifies again afterwards.
        applyStimulus(~(10'd1 << 6), 1'b1, 4'd6, 1'b0, 1'b0);
        waitValid("t5a", 20);
        compareHead("t5a");
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("t5_rst_dcba",  32'(dcba()),       32'd0);
        checkOutput("t5_rst_multi", 32'(bus_if.multi), 32'd0);
        checkOutput("t5_rst_ovr",   32'(bus_if.ovr),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(~(10'd1 << 6), 1'b1, 4'd6, 1'b0, 1'b0);
        tick(5);
        checkOutput("t5_early", 32'(bus_if.valid), 32'd0);
        tick(1);
        compareHead("t5b");
        pulseAck();
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(10);

        // Key 4 held for 40 cycles, acknowledging every valid seen.
        seen      = 0;
        first_at  = 0;
        second_at = 0;
        applyStimulus(~(10'd1 << 4), 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_if.valid) begin
                seen++;
                if (seen == 1) first_at = i;
                if (seen == 2) second_at = i;
                checkOutput("t6_dcba", 32'(dcba()), 32'd4);
                bus_if.ack = 1'b1;
            end else begin
                bus_if.ack = 1'b0;
            end
        end
        bus_if.ack = 1'b0;
        checkOutput("t6_first_at", 32'(first_at), 32'd6);
`ifdef DEC_ENC_AUTOREPEAT_EN
        checkOutput("t6_count", 32'(seen), 32'd4);
        checkOutput("t6_gap",   32'(second_at - first_at), 32'(RPT + 1));
`else
        checkOutput("t6_count", 32'(seen), 32'd1);
        checkOutput("t6_no_second", 32'(second_at), 32'd0);
`endif
        applyStimulus('1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(12);

        checkOutput("sb_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
